mul_operand_sequencer: RTL and testbench

Byte-serial front/back end for the 32-bit pipelined multiplier core behind the tt_um top wrapper. Collects two OPW-bit operands from an 8-bit input stream and issues them to the multiplier with a valid/ready handshake. Captures the 2*OPW-bit product and streams it back out one byte at a time. One transaction is in flight at a time.

---
 rtl/mul_operand_sequencer.sv | 129 ++++++++++++
 tb/tb_mul_operand_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer.sv
// Byte-serial operand collector and product streamer for the pipelined multiplier.
// Gathers two OPW-bit operands LSB-first, issues them, then drains the 2*OPW-bit product byte by byte.
module mul_operand_sequencer #(
  parameter int OPW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  output logic             mul_valid,
  input  logic             mul_ready,
  input  logic [2*OPW-1:0] prod,
  input  logic             prod_valid,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NB = OPW / 8;
  localparam int PB = 2 * NB;
  localparam int CW = (PB > 1) ? $clog2(PB) : 1;

  // state  | meaning
  // LOAD   | accepting operand bytes (A then B, LSB first)
  // ISSUE  | operands presented to multiplier, waiting for mul_ready
  // WAIT   | waiting for the product strobe
  // DRAIN  | streaming product bytes out, LSB first
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic [2*OPW-1:0] prod_q, prod_d;
  logic [7:0]       byte_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // Product byte selected by the shared counter; held while stalled because cnt_q only moves on a handshake.
  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < PB; i++) begin
      if (cnt_q == CW'(i)) byte_sel = prod_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    in_ready  = 1'b0;
    mul_valid = 1'b0;
    out_valid = 1'b0;

    if (ena) begin
      case (state_q)
        S_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            for (int i = 0; i < NB; i++) begin
              if (cnt_q == CW'(i))      a_d[i*8 +: 8] = in_byte;
              if (cnt_q == CW'(NB + i)) b_d[i*8 +: 8] = in_byte;
            end
            if (cnt_q == CW'(PB - 1)) begin
              cnt_d   = '0;
              state_d = S_ISSUE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_ISSUE: begin
          mul_valid = 1'b1;
          if (mul_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (prod_valid) begin
            prod_d  = prod;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          out_valid = 1'b1;
          if (out_ready) begin
            if (cnt_q == CW'(PB - 1)) begin
              cnt_d   = '0;
              state_d = S_LOAD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  assign mul_a    = a_q;
  assign mul_b    = b_q;
  assign out_byte = byte_sel;
  assign busy     = (state_q != S_LOAD);

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench for mul_operand_sequencer: directed operand vectors with hand-computed product bytes.
module tb_mul_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mul_a, mul_b;
  logic        mul_valid;
  logic        mul_ready;
  logic [63:0] prod;
  logic        prod_valid;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [63:0] m_prod = '0, sp_prod = '0;
  logic        m_pv = 1'b0, sp_pv = 1'b0;
  logic        toggle_out = 1'b0;

  assign prod       = sp_pv ? sp_prod : m_prod;
  assign prod_valid = m_pv | sp_pv;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;

  logic [63:0] exp_op[$];
  logic [7:0]  exp_out[$];

  mul_operand_sequencer #(.OPW(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_ready(mul_ready),
    .prod(prod), .prod_valid(prod_valid),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiplier stand-in: fixed 3-cycle latency, one-cycle product strobe.
  initial begin
    logic [31:0] a, b;
    forever begin
      @(negedge clk);
      if (rst_n && mul_valid && mul_ready) begin
        a = mul_a;
        b = mul_b;
        repeat (3) @(posedge clk);
        #1;
        m_prod = 64'(a) * 64'(b);
        m_pv   = 1'b1;
        @(posedge clk);
        #1;
        m_pv = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_out ? ~out_ready : 1'b1;
    end
  end

  // Monitor: operand issue, product bytes, and stability while stalled.
  initial begin
    logic        stall_mul = 1'b0, stall_out = 1'b0;
    logic [31:0] prev_a = '0, prev_b = '0;
    logic [7:0]  prev_o = '0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_mul = 1'b0;
        stall_out = 1'b0;
      end else begin
        if (stall_mul && mul_valid) begin
          check("mul_a_stable", {32'h0, mul_a}, {32'h0, prev_a});
          check("mul_b_stable", {32'h0, mul_b}, {32'h0, prev_b});
        end
        if (stall_out && out_valid)
          check("out_byte_stable", {56'h0, out_byte}, {56'h0, prev_o});
        if (mul_valid && mul_ready) begin
          if (exp_op.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: got a=%h b=%h expected none", mul_a, mul_b);
          end else begin
            e = exp_op.pop_front();
            check("mul_a", {32'h0, mul_a}, {32'h0, e[63:32]});
            check("mul_b", {32'h0, mul_b}, {32'h0, e[31:0]});
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out_byte: got %h expected none", out_byte);
          end else begin
            check("out_byte", {56'h0, out_byte}, {56'h0, exp_out.pop_front()});
          end
          out_cnt++;
        end
        stall_mul = mul_valid && !mul_ready;
        stall_out = out_valid && !out_ready;
        prev_a = mul_a;
        prev_b = mul_b;
        prev_o = out_byte;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n = 0;
    logic hs = 1'b0;
    in_byte  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) check("in_handshake_timeout", 64'(hs), 64'(1));
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_out(input logic [63:0] p);
    for (int i = 0; i < 8; i++) exp_out.push_back(p[i*8 +: 8]);
  endtask

  task automatic send_bytes(input logic [31:0] a, input logic [31:0] b, input int first, input int last, input int gap);
    logic [63:0] v;
    v = {b, a};
    for (int i = first; i <= last; i++) send_byte(v[i*8 +: 8], gap);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_out.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 64'(n < 2000), 64'(1));
    check("busy_idle", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_spurious();
    sp_prod = 64'hDEAD_BEEF_CAFE_F00D;
    sp_pv   = 1'b1;
    @(posedge clk);
    #1;
    sp_pv = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (out_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("out_progress_in_time", 64'(n < 2000), 64'(1));
  endtask

  initial begin
    int base;
    rst_n = 1'b0; ena = 1'b1; in_byte = '0; in_valid = 1'b0; mul_ready = 1'b1;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mul_valid", 64'(mul_valid), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mul_a", {32'h0, mul_a}, 64'h0);
    check("rst_mul_b", {32'h0, mul_b}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 3 * 5 = 15
    exp_op.push_back({32'h3, 32'h5});
    push_out(64'h0000_0000_0000_000F);
    send_bytes(32'h3, 32'h5, 0, 7, 0);
    check("issue_after_last_byte", 64'(mul_valid), 64'(1));
    wait_done();

    // Max operands
    exp_op.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    push_out(64'hFFFF_FFFE_0000_0001);
    send_bytes(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 7, 0);
    wait_done();

    // Backpressure: input gaps, mul_ready low 5 cycles, toggling out_ready
    exp_op.push_back({32'h1234_5678, 32'h0000_0100});
    push_out(64'h0000_0012_3456_7800);
    toggle_out = 1'b1;
    send_bytes(32'h1234_5678, 32'h0000_0100, 0, 6, 2);
    mul_ready = 1'b0;
    send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mul_valid_held", 64'(mul_valid), 64'(1));
      @(posedge clk); #1;
    end
    mul_ready = 1'b1;
    wait_done();
    toggle_out = 1'b0;

    // Spurious product strobes in LOAD and ISSUE: 7 * 6 = 42
    exp_op.push_back({32'h7, 32'h6});
    push_out(64'h0000_0000_0000_002A);
    send_bytes(32'h7, 32'h6, 0, 1, 0);
    pulse_spurious();
    send_bytes(32'h7, 32'h6, 2, 6, 0);
    mul_ready = 1'b0;
    send_byte(8'h00, 0);
    @(posedge clk); #1;
    pulse_spurious();
    mul_ready = 1'b1;
    wait_done();

    // Enable freeze mid-LOAD and mid-DRAIN
    exp_op.push_back({32'h0102_0304, 32'h0000_0010});
    push_out(64'h0000_0000_1020_3040);
    send_bytes(32'h0102_0304, 32'h0000_0010, 0, 2, 0);
    ena = 1'b0; in_valid = 1'b1; in_byte = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("freeze_load_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ena = 1'b1;
    base = out_cnt;
    send_bytes(32'h0102_0304, 32'h0000_0010, 3, 7, 0);
    wait_out(base + 2);
    @(posedge clk); #1;
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("freeze_drain_out_valid", 64'(out_valid), 64'(0));
      check("freeze_drain_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    ena = 1'b1;
    wait_done();

    // Async reset mid-DRAIN, then a fresh transaction
    exp_op.push_back({32'h2, 32'h3});
    push_out(64'h0000_0000_0000_0006);
    base = out_cnt;
    send_bytes(32'h2, 32'h3, 0, 7, 0);
    wait_out(base + 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_mul_a", {32'h0, mul_a}, 64'h0);
    check("arst_in_ready", 64'(in_ready), 64'(1));
    exp_out.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_op.push_back({32'h0001_0001, 32'h0001_0001});
    push_out(64'h0000_0001_0002_0001);
    send_bytes(32'h0001_0001, 32'h0001_0001, 0, 7, 0);
    wait_done();

    check("op_queue_empty", 64'(exp_op.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
